station_tracker: RTL and testbench

STATION_TRACKER -- requirements
Module: station_tracker

---
 rtl/station_tracker.sv | 174 +++++++++++++++++
 tb/tb_station_tracker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/station_tracker.sv
// Station tracker: follows a trip from cmd_go to arrival using barcode station reads.
// Optional trip timeout is compiled in with `define STN_TIMEOUT_EN.
module station_tracker #(
  parameter int unsigned TMO_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       cmd_go,
  input  logic [7:0] dest_ID,
  input  logic       cmd_stop,
  output logic       in_transit,
  output logic       arrived,
  output logic       err_ID,
  output logic       tmo,
  output logic [7:0] last_ID,
  output logic [3:0] stn_cnt
);

  typedef enum logic [1:0] {IDLE, TRAVEL, CHK} state_t;

  state_t     state_reg, state_next;
  logic [7:0] dest_reg, dest_next;
  logic [7:0] cap_reg, cap_next;
  logic [7:0] last_reg, last_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       clr_reg, clr_next;
  logic       arr_reg, arr_next;
  logic       err_reg, err_next;
  logic       hold_reg;
  logic       read;
  logic       go_ok;

  function automatic logic id_ok(input logic [7:0] v);
    return v[7:6] == 2'b00;
  endfunction

  // ID_vld stays high while clr is out and for one cycle of reader latency after it
  assign read  = ID_vld && !clr_reg && !hold_reg;
  assign go_ok = cmd_go && id_ok(dest_ID);

`ifdef STN_TIMEOUT_EN
  logic [23:0] tcnt_reg, tcnt_next;
  logic        tmo_reg, tmo_next;
  logic        tmo_hit;

  assign tmo_hit = (state_reg == TRAVEL) && (tcnt_reg == 24'(TMO_CYC - 1));

  always_comb begin
    tcnt_next = tcnt_reg;
    if (state_next == TRAVEL && state_reg != TRAVEL) begin
      tcnt_next = '0;
    end else if (state_reg == TRAVEL) begin
      tcnt_next = ID_vld ? 24'd0 : tcnt_reg + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_reg <= '0;
      tmo_reg  <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      tmo_reg  <= tmo_next;
    end
  end

  assign tmo = tmo_reg;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    dest_next  = dest_reg;
    cap_next   = cap_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    clr_next   = 1'b0;
    arr_next   = 1'b0;
    err_next   = 1'b0;
`ifdef STN_TIMEOUT_EN
    tmo_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (read) begin
          clr_next = 1'b1;
          if (id_ok(ID)) last_next = ID;
        end
        if (go_ok) begin
          dest_next  = dest_ID;
          cnt_next   = '0;
          state_next = TRAVEL;
        end
      end
      TRAVEL: begin
        if (cmd_stop) begin
          state_next = IDLE;
          if (read) clr_next = 1'b1;
        end else begin
          if (go_ok) begin
            dest_next = dest_ID;
            cnt_next  = '0;
          end
          if (read) begin
            cap_next   = ID;
            clr_next   = 1'b1;
            state_next = CHK;
          end
`ifdef STN_TIMEOUT_EN
          else if (tmo_hit) begin
            state_next = IDLE;
            tmo_next   = 1'b1;
          end
`endif
        end
      end
      CHK: begin
        if (cmd_stop) begin
          state_next = IDLE;
        end else if (id_ok(cap_reg)) begin
          last_next = cap_reg;
          if (cnt_reg != 4'hF) cnt_next = cnt_reg + 4'd1;
          // compare against dest_reg, which a go in the read cycle has already reloaded
          if (cap_reg == dest_reg) begin
            state_next = IDLE;
            arr_next   = 1'b1;
          end else begin
            state_next = TRAVEL;
          end
        end else begin
          err_next   = 1'b1;
          state_next = TRAVEL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dest_reg  <= '0;
      cap_reg   <= '0;
      last_reg  <= '0;
      cnt_reg   <= '0;
      clr_reg   <= 1'b0;
      arr_reg   <= 1'b0;
      err_reg   <= 1'b0;
      hold_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dest_reg  <= dest_next;
      cap_reg   <= cap_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      clr_reg   <= clr_next;
      arr_reg   <= arr_next;
      err_reg   <= err_next;
      hold_reg  <= clr_reg;
    end
  end

  assign clr_ID_vld = clr_reg;
  assign arrived    = arr_reg;
  assign err_ID     = err_reg;
  assign last_ID    = last_reg;
  assign stn_cnt    = cnt_reg;
  assign in_transit = (state_reg == TRAVEL) || (state_reg == CHK);

endmodule

// File: tb/tb_station_tracker.sv
// Directed bench for station_tracker with an expected-value queue and pulse counters.
module tb_station_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       cmd_go;
  logic [7:0] dest_ID;
  logic       cmd_stop;
  logic       in_transit;
  logic       arrived;
  logic       err_ID;
  logic       tmo;
  logic [7:0] last_ID;
  logic [3:0] stn_cnt;

  station_tracker #(.TMO_CYC(100)) dut (
    .clk(clk), .rst(rst), .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld),
    .cmd_go(cmd_go), .dest_ID(dest_ID), .cmd_stop(cmd_stop),
    .in_transit(in_transit), .arrived(arrived), .err_ID(err_ID), .tmo(tmo),
    .last_ID(last_ID), .stn_cnt(stn_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_clr = 0, n_arr = 0, n_err = 0, n_tmo = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (clr_ID_vld) n_clr++;
      if (arrived)    n_arr++;
      if (err_ID)     n_err++;
      if (tmo)        n_tmo++;
    end
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty got %0h", obs);
    end else begin
      e = sb.pop_front();
      $display("check %s got %0h expected %0h", e.tag, obs, e.val);
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic go(input logic [7:0] d);
    @(negedge clk);
    cmd_go = 1'b1;
    dest_ID = d;
    @(negedge clk);
    cmd_go = 1'b0;
  endtask

  task automatic stop();
    @(negedge clk);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
  endtask

  // Reader model: hold ID_vld until one cycle after the clear pulse is seen.
  task automatic rd(input logic [7:0] id, input bit stp, input bit g, input logic [7:0] gd);
    bit seen = 1'b0;
    @(negedge clk);
    ID = id; ID_vld = 1'b1; cmd_stop = stp; cmd_go = g; dest_ID = gd;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      cmd_stop = 1'b0; cmd_go = 1'b0;
      if (clr_ID_vld) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL clr_wait id=%0h got no clr_ID_vld required one", id);
    end
    @(negedge clk);
    @(negedge clk);
    ID_vld = 1'b0;
  endtask

  initial begin
    int c_clr, c_arr, c_err, c_tmo, cyc;
    bit seen;
    rst = 1'b1; ID = '0; ID_vld = 1'b0; cmd_go = 1'b0; dest_ID = '0; cmd_stop = 1'b0;

    // reset state
    @(negedge clk);
    push("rst_in_transit", 0); cmp(in_transit);
    push("rst_last_id", 0);    cmp(last_ID);
    push("rst_stn_cnt", 0);    cmp(stn_cnt);
    push("rst_pulses", 0);     cmp({clr_ID_vld, arrived, err_ID, tmo});
    @(negedge clk);
    rst = 1'b0;

    // trip: dest 0x3A, reads 0x36 then 0x3A
    c_clr = n_clr; c_arr = n_arr;
    go(8'h3A);
    push("trip_in_transit", 1); cmp(in_transit);
    rd(8'h36, 0, 0, 0);
    push("trip_mid_last", 8'h36); cmp(last_ID);
    push("trip_mid_cnt", 1);      cmp(stn_cnt);
    push("trip_mid_transit", 1);  cmp(in_transit);
    rd(8'h3A, 0, 0, 0);
    push("trip_last", 8'h3A);  cmp(last_ID);
    push("trip_cnt", 2);       cmp(stn_cnt);
    push("trip_arrived", 1);   cmp(n_arr - c_arr);
    push("trip_clr", 2);       cmp(n_clr - c_clr);
    push("trip_idle", 0);      cmp(in_transit);

    // invalid read during a trip
    go(8'h3A);
    rd(8'h10, 0, 0, 0);
    c_clr = n_clr; c_err = n_err;
    rd(8'h80, 0, 0, 0);
    push("bad_err", 1);        cmp(n_err - c_err);
    push("bad_cnt", 1);        cmp(stn_cnt);
    push("bad_last", 8'h10);   cmp(last_ID);
    push("bad_clr", 1);        cmp(n_clr - c_clr);
    push("bad_transit", 1);    cmp(in_transit);
    c_arr = n_arr;
    stop();
    push("stop_idle", 0);      cmp(in_transit);
    push("stop_no_arr", 0);    cmp(n_arr - c_arr);

    // stop together with a matching read
    go(8'h3A);
    c_clr = n_clr; c_arr = n_arr;
    rd(8'h3A, 1, 0, 0);
    repeat (3) @(negedge clk);
    push("stopmatch_arr", 0);  cmp(n_arr - c_arr);
    push("stopmatch_clr", 1);  cmp(n_clr - c_clr);
    push("stopmatch_idle", 0); cmp(in_transit);

    // invalid destination ignored; IDLE flush
    go(8'h80);
    push("baddest_idle", 0);   cmp(in_transit);
    c_clr = n_clr; c_arr = n_arr;
    rd(8'h25, 0, 0, 0);
    push("flush_clr", 1);      cmp(n_clr - c_clr);
    push("flush_cnt", 0);      cmp(stn_cnt);
    push("flush_last", 8'h25); cmp(last_ID);
    push("flush_idle", 0);     cmp(in_transit);

    // stn_cnt saturation
    go(8'h3F);
    for (int i = 1; i <= 16; i++) rd(8'(i), 0, 0, 0);
    push("sat_cnt", 15);       cmp(stn_cnt);
    c_arr = n_arr;
    rd(8'h3F, 0, 0, 0);
    push("sat_arr", 1);        cmp(n_arr - c_arr);
    push("sat_cnt_hold", 15);  cmp(stn_cnt);

    // destination reload in the same cycle as a read
    go(8'h11);
    rd(8'h05, 0, 0, 0);
    c_arr = n_arr;
    rd(8'h22, 0, 1, 8'h22);
    push("reload_arr", 1);     cmp(n_arr - c_arr);
    push("reload_cnt", 1);     cmp(stn_cnt);
    push("reload_idle", 0);    cmp(in_transit);

    // trip timeout
    c_tmo = n_tmo;
    go(8'h3A);
`ifdef STN_TIMEOUT_EN
    seen = 1'b0; cyc = 0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      @(negedge clk);
      if (tmo) begin seen = 1'b1; cyc = i; end
    end
    push("tmo_cycle", 100);    cmp(cyc);
    @(negedge clk);
    push("tmo_idle", 0);       cmp(in_transit);
    push("tmo_count", 1);      cmp(n_tmo - c_tmo);
`else
    seen = 1'b0; cyc = 0;
    repeat (200) @(negedge clk);
    push("notmo_transit", 1);  cmp(in_transit);
    push("notmo_count", 0);    cmp(n_tmo - c_tmo);
    stop();
`endif

    // reset in the middle of CHK
    go(8'h3A);
    c_arr = n_arr;
    @(negedge clk);
    ID = 8'h3A; ID_vld = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    push("rstchk_outs", 0);
    cmp({in_transit, clr_ID_vld, arrived, err_ID, tmo, last_ID, stn_cnt});
    @(negedge clk);
    rst = 1'b0; ID_vld = 1'b0;
    repeat (4) @(negedge clk);
    push("rstchk_no_arr", 0);  cmp(n_arr - c_arr);
    push("rstchk_idle", 0);    cmp(in_transit);

    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
